// File: rtl/fdif_if.sv
// fdif_if: handshake and data bundle for the fdif forward 8-point FFT.
//   start          request to capture xr*/xi* and begin a transform
//   xr0..xr7       real parts of x[0..7], signed DW bits
//   xi0..xi7       imaginary parts of x[0..7], signed DW bits
//   sel            output bin index k
//   yr, yi         X[sel], signed OW bits
//   busy, done     status: compute in progress / result held
// master drives requests and samples results; slave is the FFT core.
interface fdif_if #(
   parameter int DW = 8,
   parameter int OW = DW + 3
);
   logic                 start;
   logic signed [DW-1:0] xr0, xr1, xr2, xr3, xr4, xr5, xr6, xr7;
   logic signed [DW-1:0] xi0, xi1, xi2, xi3, xi4, xi5, xi6, xi7;
   logic [2:0]           sel;
   logic signed [OW-1:0] yr;
   logic signed [OW-1:0] yi;
   logic                 busy;
   logic                 done;

   modport master (
      output start, sel,
      output xr0, xr1, xr2, xr3, xr4, xr5, xr6, xr7,
      output xi0, xi1, xi2, xi3, xi4, xi5, xi6, xi7,
      input  yr, yi, busy, done
   );

   modport slave (
      input  start, sel,
      input  xr0, xr1, xr2, xr3, xr4, xr5, xr6, xr7,
      input  xi0, xi1, xi2, xi3, xi4, xi5, xi6, xi7,
      output yr, yi, busy, done
   );
endinterface

// File: rtl/fdif.sv
// fdif: forward 8-point radix-2 decimation-in-frequency FFT.
// Captures 8 complex samples on start, then performs one butterfly per clock
// (3 stages x 4 butterflies) in place on 8 complex OW-bit registers. Results
// are held and read combinationally in natural order via bus.sel.
// Ports:
//   clk    clock
//   rst    synchronous active-high reset
//   bus    fdif_if slave: start, xr0..7/xi0..7, sel in; yr, yi, busy, done out
module fdif #(
   parameter int DW = 8,
   parameter int OW = DW + 3,
   parameter int TW = 8
) (
   input logic   clk,
   input logic   rst,
   fdif_if.slave bus
);

   // Product width: OW x TW plus one bit for the sum of two products.
   localparam int PW   = OW + TW + 1;
   // cos(pi/4) in Q1.(TW-1); 91 for TW=8.
   localparam int KINT = int'((2.0 ** (TW - 1)) * 0.7071067811865476);
   localparam logic signed [PW-1:0] KW = PW'(KINT);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e               state_q, state_d;
   logic [1:0]           stage_q, stage_d;
   logic [1:0]           bf_q, bf_d;
   logic signed [OW-1:0] wr_q [8];
   logic signed [OW-1:0] wi_q [8];
   logic signed [OW-1:0] wr_d [8];
   logic signed [OW-1:0] wi_d [8];

   logic signed [DW-1:0] xr [8];
   logic signed [DW-1:0] xi [8];

   assign xr[0] = bus.xr0;
   assign xr[1] = bus.xr1;
   assign xr[2] = bus.xr2;
   assign xr[3] = bus.xr3;
   assign xr[4] = bus.xr4;
   assign xr[5] = bus.xr5;
   assign xr[6] = bus.xr6;
   assign xr[7] = bus.xr7;
   assign xi[0] = bus.xi0;
   assign xi[1] = bus.xi1;
   assign xi[2] = bus.xi2;
   assign xi[3] = bus.xi3;
   assign xi[4] = bus.xi4;
   assign xi[5] = bus.xi5;
   assign xi[6] = bus.xi6;
   assign xi[7] = bus.xi7;

   // Butterfly addressing: span h = 4>>stage, a = (bf/h)*2h + bf%h, b = a+h,
   // twiddle exponent (bf%h) << stage.
   logic [2:0] ia, ib;
   logic [1:0] tw;

   always_comb begin
      ia = '0;
      ib = '0;
      tw = '0;
      case (stage_q)
         2'd0: begin
            ia = {1'b0, bf_q};
            ib = {1'b1, bf_q};
            tw = bf_q;
         end
         2'd1: begin
            ia = {bf_q[1], 1'b0, bf_q[0]};
            ib = {bf_q[1], 1'b1, bf_q[0]};
            tw = {bf_q[0], 1'b0};
         end
         default: begin
            ia = {bf_q, 1'b0};
            ib = {bf_q, 1'b1};
            tw = 2'd0;
         end
      endcase
   end

   logic signed [OW-1:0] ar, ai, br, bi, sr, si, dr, di, rr, ri;
   logic signed [PW-1:0] dre, die, mr, mi, pr, pi;

   assign ar  = wr_q[ia];
   assign ai  = wi_q[ia];
   assign br  = wr_q[ib];
   assign bi  = wi_q[ib];
   assign sr  = ar + br;
   assign si  = ai + bi;
   assign dr  = ar - br;
   assign di  = ai - bi;
   assign dre = PW'(dr);
   assign die = PW'(di);
   // Both odd twiddles have |re| = |im| = K, so two multipliers suffice.
   assign mr  = dre * KW;
   assign mi  = die * KW;

   always_comb begin
      // W^1 = K - jK : (dr + j di)(K - jK) = K(dr+di) + jK(di-dr)
      pr = mr + mi;
      pi = mi - mr;
      if (tw == 2'd3) begin
         // W^3 = -K - jK : K(di-dr) + jK(-dr-di)
         pr = mi - mr;
         pi = -mr - mi;
      end
   end

   always_comb begin
      rr = dr;
      ri = di;
      case (tw)
         2'd0: begin
            rr = dr;
            ri = di;
         end
         2'd2: begin
            // Multiply by -j.
            rr = di;
            ri = -dr;
         end
         default: begin
            rr = OW'(pr >>> (TW - 1));
            ri = OW'(pi >>> (TW - 1));
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      bf_d    = bf_q;
      wr_d    = wr_q;
      wi_d    = wi_q;
      case (state_q)
         StIdle, StDone: begin
            if (bus.start) begin
               for (int i = 0; i < 8; i++) begin
                  wr_d[i] = OW'(xr[i]);
                  wi_d[i] = OW'(xi[i]);
               end
               stage_d = '0;
               bf_d    = '0;
               state_d = StCalc;
            end
         end
         StCalc: begin
            wr_d[ia] = sr;
            wi_d[ia] = si;
            wr_d[ib] = rr;
            wi_d[ib] = ri;
            bf_d     = bf_q + 2'd1;
            if (bf_q == 2'd3) begin
               stage_d = stage_q + 2'd1;
               if (stage_q == 2'd2) begin
                  stage_d = '0;
                  state_d = StDone;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         stage_q <= '0;
         bf_q    <= '0;
         for (int i = 0; i < 8; i++) begin
            wr_q[i] <= '0;
            wi_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         bf_q    <= bf_d;
         wr_q    <= wr_d;
         wi_q    <= wi_d;
      end
   end

   // DIF output is bit-reversed in the working store.
   logic [2:0] rsel;
   assign rsel     = {bus.sel[0], bus.sel[1], bus.sel[2]};
   assign bus.yr   = wr_q[rsel];
   assign bus.yi   = wi_q[rsel];
   assign bus.busy = (state_q == StCalc);
   assign bus.done = (state_q == StDone);

endmodule

// File: tb/tb_fdif.sv
// tb_fdif: directed self-checking bench for fdif.
module tb_fdif;
   localparam int DW = 8;
   localparam int OW = DW + 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fdif_if #(.DW(DW), .OW(OW)) bus ();

   fdif #(.DW(DW), .OW(OW), .TW(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int tests = 0;
   int fails = 0;
   int vr [8];
   int vi [8];
   int er [8];
   int ei [8];

   task automatic apply_x();
      bus.xr0 = DW'(vr[0]); bus.xr1 = DW'(vr[1]); bus.xr2 = DW'(vr[2]); bus.xr3 = DW'(vr[3]);
      bus.xr4 = DW'(vr[4]); bus.xr5 = DW'(vr[5]); bus.xr6 = DW'(vr[6]); bus.xr7 = DW'(vr[7]);
      bus.xi0 = DW'(vi[0]); bus.xi1 = DW'(vi[1]); bus.xi2 = DW'(vi[2]); bus.xi3 = DW'(vi[3]);
      bus.xi4 = DW'(vi[4]); bus.xi5 = DW'(vi[5]); bus.xi6 = DW'(vi[6]); bus.xi7 = DW'(vi[7]);
   endtask

   // Leaves the bench at the falling edge right after the capture edge.
   task automatic pulse_start();
      @(negedge clk);
      apply_x();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Counts edges since capture (capture = 1) until done, bounded.
   task automatic wait_done(output int edges);
      edges = 1;
      while (!bus.done && edges < 40) begin
         @(negedge clk);
         edges++;
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      vr        = '{5, -3, 7, 1, 2, 9, -8, 4};
      vi        = '{1, 2, 3, 4, 5, 6, 7, 8};
      apply_x();
      bus.start = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         fails++;
         $display("FAIL reset_status: busy=%b done=%b, want busy=0 done=0", bus.busy, bus.done);
      end
      for (int k = 0; k < 8; k++) begin
         bus.sel = 3'(k);
         #1;
         tests++;
         if (bus.yr !== '0 || bus.yi !== '0) begin
            fails++;
            $display("FAIL reset_zero bin %0d: got %0d,%0d want 0,0", k, bus.yr, bus.yi);
         end
      end
      rst       = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      tests++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         fails++;
         $display("FAIL reset_release: busy=%b done=%b, want 0 0", bus.busy, bus.done);
      end
   endtask

   task automatic test_ramp();
      vr = '{1, 0, 2, 0, 3, 0, 4, 0};
      vi = '{0, 0, 0, 0, 0, 0, 0, 0};
      er = '{10, -2, -2, -2, 10, -2, -2, -2};
      ei = '{0, 2, 0, -2, 0, 2, 0, -2};
      pulse_start();
      tests++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
         fails++;
         $display("FAIL ramp_edge1: busy=%b done=%b, want 1 0", bus.busy, bus.done);
      end
      for (int e = 2; e <= 12; e++) begin
         @(negedge clk);
         tests++;
         if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL ramp_busy edge %0d: busy=%b done=%b, want 1 0", e, bus.busy, bus.done);
         end
      end
      @(negedge clk);
      tests++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin
         fails++;
         $display("FAIL ramp_edge13: busy=%b done=%b, want 0 1", bus.busy, bus.done);
      end
      for (int k = 0; k < 8; k++) begin
         bus.sel = 3'(k);
         #1;
         tests++;
         if (bus.yr !== OW'(er[k]) || bus.yi !== OW'(ei[k])) begin
            fails++;
            $display("FAIL ramp bin %0d: got %0d,%0d want %0d,%0d", k, bus.yr, bus.yi, er[k], ei[k]);
         end
      end
   endtask

   task automatic test_dc_alt();
      int edges;
      for (int t = 0; t < 2; t++) begin
         if (t == 0) begin
            vr = '{1, 1, 1, 1, 1, 1, 1, 1};
            er = '{8, 0, 0, 0, 0, 0, 0, 0};
         end else begin
            vr = '{2, 0, 2, 0, 2, 0, 2, 0};
            er = '{8, 0, 0, 0, 8, 0, 0, 0};
         end
         vi = '{0, 0, 0, 0, 0, 0, 0, 0};
         ei = '{0, 0, 0, 0, 0, 0, 0, 0};
         pulse_start();
         wait_done(edges);
         tests++;
         if (edges != 13) begin
            fails++;
            $display("FAIL dc_alt%0d_latency: got %0d edges want 13", t, edges);
         end
         for (int k = 0; k < 8; k++) begin
            bus.sel = 3'(k);
            #1;
            tests++;
            if (bus.yr !== OW'(er[k]) || bus.yi !== OW'(ei[k])) begin
               fails++;
               $display("FAIL dc_alt%0d bin %0d: got %0d,%0d want %0d,%0d",
                        t, k, bus.yr, bus.yi, er[k], ei[k]);
            end
         end
      end
   endtask

   task automatic test_impulse();
      int edges;
      int dre, dim, tol;
      vr = '{0, 64, 0, 0, 0, 0, 0, 0};
      vi = '{0, 0, 0, 0, 0, 0, 0, 0};
      er = '{64, 45, 0, -45, -64, -45, 0, 45};
      ei = '{0, -45, -64, -45, 0, 45, 64, 45};
      pulse_start();
      wait_done(edges);
      tests++;
      if (edges != 13) begin
         fails++;
         $display("FAIL impulse_latency: got %0d edges want 13", edges);
      end
      for (int k = 0; k < 8; k++) begin
         bus.sel = 3'(k);
         #1;
         tol = (k % 2 == 1) ? 1 : 0;
         dre = int'(bus.yr) - er[k];
         dim = int'(bus.yi) - ei[k];
         tests++;
         if ($isunknown({bus.yr, bus.yi}) || dre > tol || dre < -tol || dim > tol || dim < -tol)
         begin
            fails++;
            $display("FAIL impulse bin %0d: got %0d,%0d want %0d,%0d (+-%0d)",
                     k, bus.yr, bus.yi, er[k], ei[k], tol);
         end
      end
   endtask

   // start during CALC cycle 5 (edge 6) with new inputs is ignored.
   task automatic test_start_ignored();
      int edges;
      vr = '{1, 0, 2, 0, 3, 0, 4, 0};
      vi = '{0, 0, 0, 0, 0, 0, 0, 0};
      er = '{10, -2, -2, -2, 10, -2, -2, -2};
      ei = '{0, 2, 0, -2, 0, 2, 0, -2};
      pulse_start();
      repeat (4) @(negedge clk);
      vr = '{9, 9, 9, 9, 9, 9, 9, 9};
      apply_x();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      edges = 6;
      while (!bus.done && edges < 40) begin
         @(negedge clk);
         edges++;
      end
      tests++;
      if (edges != 13) begin
         fails++;
         $display("FAIL ignored_latency: got %0d edges want 13", edges);
      end
      for (int k = 0; k < 8; k++) begin
         bus.sel = 3'(k);
         #1;
         tests++;
         if (bus.yr !== OW'(er[k]) || bus.yi !== OW'(ei[k])) begin
            fails++;
            $display("FAIL ignored bin %0d: got %0d,%0d want %0d,%0d",
                     k, bus.yr, bus.yi, er[k], ei[k]);
         end
      end
   endtask

   // Entered with done=1; restart with a new vector.
   task automatic test_restart_in_done();
      int edges;
      vr = '{2, 0, 2, 0, 2, 0, 2, 0};
      vi = '{0, 0, 0, 0, 0, 0, 0, 0};
      er = '{8, 0, 0, 0, 8, 0, 0, 0};
      ei = '{0, 0, 0, 0, 0, 0, 0, 0};
      pulse_start();
      tests++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
         fails++;
         $display("FAIL restart_status: busy=%b done=%b, want 1 0", bus.busy, bus.done);
      end
      wait_done(edges);
      tests++;
      if (edges != 13) begin
         fails++;
         $display("FAIL restart_latency: got %0d edges want 13", edges);
      end
      for (int k = 0; k < 8; k++) begin
         bus.sel = 3'(k);
         #1;
         tests++;
         if (bus.yr !== OW'(er[k]) || bus.yi !== OW'(ei[k])) begin
            fails++;
            $display("FAIL restart bin %0d: got %0d,%0d want %0d,%0d",
                     k, bus.yr, bus.yi, er[k], ei[k]);
         end
      end
   endtask

   task automatic test_reset_mid_calc();
      int edges;
      vr = '{1, 1, 1, 1, 1, 1, 1, 1};
      vi = '{3, -1, 4, 1, -5, 9, 2, -6};
      pulse_start();
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         fails++;
         $display("FAIL midreset_status: busy=%b done=%b, want 0 0", bus.busy, bus.done);
      end
      for (int k = 0; k < 8; k++) begin
         bus.sel = 3'(k);
         #1;
         tests++;
         if (bus.yr !== '0 || bus.yi !== '0) begin
            fails++;
            $display("FAIL midreset_zero bin %0d: got %0d,%0d want 0,0", k, bus.yr, bus.yi);
         end
      end
      vr = '{1, 0, 2, 0, 3, 0, 4, 0};
      vi = '{0, 0, 0, 0, 0, 0, 0, 0};
      er = '{10, -2, -2, -2, 10, -2, -2, -2};
      ei = '{0, 2, 0, -2, 0, 2, 0, -2};
      pulse_start();
      wait_done(edges);
      tests++;
      if (edges != 13) begin
         fails++;
         $display("FAIL midreset_latency: got %0d edges want 13", edges);
      end
      for (int k = 0; k < 8; k++) begin
         bus.sel = 3'(k);
         #1;
         tests++;
         if (bus.yr !== OW'(er[k]) || bus.yi !== OW'(ei[k])) begin
            fails++;
            $display("FAIL midreset_rerun bin %0d: got %0d,%0d want %0d,%0d",
                     k, bus.yr, bus.yi, er[k], ei[k]);
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.sel   = '0;
      vr        = '{0, 0, 0, 0, 0, 0, 0, 0};
      vi        = '{0, 0, 0, 0, 0, 0, 0, 0};
      apply_x();
      test_reset();
      test_ramp();
      test_dc_alt();
      test_impulse();
      test_start_ignored();
      test_restart_in_done();
      test_reset_mid_calc();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fdif.md
Name: fdif

Overview:
- Forward 8-point radix-2 decimation-in-frequency FFT. Inverse-direction counterpart to the team's idif block.
- Captures 8 complex samples in parallel on a start pulse and computes the transform sequentially, one butterfly per clock (3 stages × 4 butterflies).
- Results are held and read out in natural order through a sel-indexed mux, using the same read style as idif.
- Produces spectra that idif consumes, giving an fdif→idif round-trip test path.

Parameters:
- DW, 8, input sample width (signed two's complement, real and imaginary each).
- OW, DW+3, output/internal width; 3 bits of growth, no inter-stage scaling.
- TW, 8, twiddle width, signed Q1.(TW-1); W8^1 magnitude constant = 91 for TW=8.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle request to capture inputs and begin a transform.
- xr0..xr7  in  DW each  real parts of x[0..7], signed.
- xi0..xi7  in  DW each  imaginary parts of x[0..7], signed.
- sel  in  3  output bin index k.
- yr  out  OW  real part of X[sel], signed.
- yi  out  OW  imaginary part of X[sel], signed.
- busy  out  1  high while capture or compute is in progress.
- done  out  1  high while a valid result is held.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, busy=0, done=0.
  - Stage counter, butterfly counter and all 8 working registers cleared, so yr=yi=0 for every sel.
- Working store: 8 complex registers of OW bits. Inputs are sign-extended to OW on capture.
- FSM states IDLE, CALC, DONE:
  - IDLE: on an edge with start=1, capture all 16 inputs, set stage=0, bf=0, busy=1, and go to CALC.
  - CALC: each edge performs one butterfly.
    - Stage s has span h = 4>>s.
    - Butterfly bf pairs index a = (bf/h)·2h + bf mod h with index b = a+h.
    - Update: A' = A+B; B' = (A−B)·W8^((bf mod h)·2^s).
    - After bf=3, bf wraps to 0 and stage increments.
    - After stage 2, bf 3: go to DONE, busy=0, done=1.
  - DONE: hold results. start=1 recaptures exactly as from IDLE: done→0, busy→1.
- Latency: done rises on the 13th rising edge counting the capture edge as edge 1 (1 capture + 12 butterflies).
- start is ignored while in CALC; no restart and no queuing.
- Twiddles are the forward direction, W8^n = e^(−j2πn/8), as constants (TW=8):
  - W^0 = (127→treated as exact 1, bypass multiply).
  - W^1 = (91, −91).
  - W^2 = (0, −1) exact swap/negate, no multiply: (re,im) → (im, −re).
  - W^3 = (−91, −91).
- Multiply path:
  - Full-precision products, then arithmetic shift right by TW−1 (floor), then truncate to OW.
  - Only W^1 and W^3 use multipliers.
- Overflow: none possible for OW=DW+3 with trivial twiddles. Non-trivial twiddle paths wrap silently.
- Output ordering:
  - DIF output lands in bit-reversed order.
  - yr/yi = working[bitrev(sel)], read combinationally.
  - Valid only when done=1; undefined (but stable) otherwise.
- Reset mid-CALC: abort on that edge, return to IDLE with all state cleared, done=0.
- Reset and start in the same cycle: reset wins.

Test Plan:
- rst held, then released. Outputs yr=yi=0 for all sel, busy=0, done=0. A start while rst=1 has no effect.
- x = {1,0,2,0,3,0,4,0} real, start pulse:
  - busy=1 for 12 cycles, done on edge 13.
  - X = {10, −2+2j, −2, −2−2j, 10, −2+2j, −2, −2−2j}, exact.
- x = {1,1,1,1,1,1,1,1}: X = {8,0,0,0,0,0,0,0}. x = {2,0,2,0,2,0,2,0}: X = {8,0,0,0,8,0,0,0}. All exact; sweep sel 0..7.
- Impulse x[1]=64, others 0:
  - X0=64, X2=−64j, X4=−64, X6=+64j, exact.
  - X1≈45−45j, X3≈−45−45j, X5≈−45+45j, X7≈45+45j, each within ±1 LSB.
- Timing/handshake: start at cycle 5 of CALC is ignored (result matches first input set). Start in DONE with new inputs gives done=0 next cycle and new result 13 edges later.
- rst asserted at CALC cycle 6 gives IDLE, done=0, zeros. Next start completes correctly.
